// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Sits on the PLL output clock. It filters the raw PLL LOCK and produces a
//   clean, registered, active-high synchronous reset for downstream logic.
//   Reset is released only after lock has been stable for LOCK_FILTER cycles
//   and a further HOLD_CYCLES hold period has elapsed. Loss of lock or a user
//   reset request puts the downstream design back into reset.
//
// Parameters:
//   LOCK_FILTER - consecutive synchronised-lock-high cycles before lock is trusted (>=1)
//   HOLD_CYCLES - cycles sys_reset stays high after lock is trusted or after a request (>=1)
//   CNT_W       - filter/hold counter width, must hold max(LOCK_FILTER, HOLD_CYCLES)
//
// Ports:
//   clock         in   PLL output clock (only clock)
//   reset_n       in   async active-low reset of this block
//   pll_lock      in   raw PLL LOCK, asynchronous to clock
//   rst_req       in   user reset request, asynchronous, active-high level
//   sys_reset     out  registered active-high reset for downstream logic
//   ready         out  registered, high only in RUN
//   state_dbg     out  current state (WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3)
//   lock_loss_cnt out  [7:0] saturating count of RUN->WAIT_LOCK transitions
//                      (present only when PLL_LOCK_LOSS_COUNT_EN is defined)
//
// Optional feature macro: PLL_LOCK_LOSS_COUNT_EN
// ----------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int LOCK_FILTER = 1024,
   parameter int HOLD_CYCLES = 256,
   parameter int CNT_W       = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       pll_lock,
   input  logic       rst_req,
   output logic       sys_reset,
   output logic       ready,
`ifdef PLL_LOCK_LOSS_COUNT_EN
   output logic [7:0] lock_loss_cnt,
`endif
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] LF_C     = CNT_W'(LOCK_FILTER);
   localparam logic [CNT_W-1:0] HC_LAST  = CNT_W'(HOLD_CYCLES - 1);

   // -------------------------------------------------------------------------
   // 2-flop synchronisers for the asynchronous inputs
   // -------------------------------------------------------------------------
   logic lock_meta_q, lock_s_q;
   logic req_meta_q, req_s_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         req_meta_q  <= 1'b0;
         req_s_q     <= 1'b0;
      end else begin
         lock_meta_q <= pll_lock;
         lock_s_q    <= lock_meta_q;
         req_meta_q  <= rst_req;
         req_s_q     <= req_meta_q;
      end
   end

   // -------------------------------------------------------------------------
   // Sequencer FSM
   // -------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [CNT_W-1:0] flt_q, flt_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             sys_reset_q, sys_reset_d;
   logic             ready_q, ready_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= WAIT_LOCK;
         flt_q       <= CNT_ZERO;
         hold_q      <= CNT_ZERO;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         flt_q       <= flt_d;
         hold_q      <= hold_d;
         sys_reset_q <= sys_reset_d;
         ready_q     <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      flt_d   = flt_q;
      hold_d  = hold_q;
      unique case (state_q)
         WAIT_LOCK: begin
            flt_d  = CNT_ZERO;
            hold_d = CNT_ZERO;
            if (lock_s_q) begin
               state_d = STABLE;
               flt_d   = CNT_ONE;
            end
         end
         STABLE: begin
            // flt_q counts STABLE cycles starting at 1, so LOCK_FILTER=1
            // leaves after exactly one STABLE cycle.
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
               flt_d   = CNT_ZERO;
            end else if (flt_q >= LF_C) begin
               state_d = HOLD;
               hold_d  = CNT_ZERO;
            end else if (flt_q != CNT_MAX) begin
               flt_d = flt_q + CNT_ONE;
            end
         end
         HOLD: begin
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
               flt_d   = CNT_ZERO;
               hold_d  = CNT_ZERO;
            end else if (req_s_q) begin
               hold_d = CNT_ZERO;
            end else if (hold_q >= HC_LAST) begin
               state_d = RUN;
            end else if (hold_q != CNT_MAX) begin
               hold_d = hold_q + CNT_ONE;
            end
         end
         RUN: begin
            // Lock loss wins over a simultaneous request.
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
               flt_d   = CNT_ZERO;
               hold_d  = CNT_ZERO;
            end else if (req_s_q) begin
               state_d = HOLD;
               hold_d  = CNT_ZERO;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
      // Registered from the next state so outputs move with the state register.
      sys_reset_d = (state_d != RUN);
      ready_d     = (state_d == RUN);
   end

   assign sys_reset = sys_reset_q;
   assign ready     = ready_q;
   assign state_dbg = state_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
   // -------------------------------------------------------------------------
   // Saturating count of lock losses while running
   // -------------------------------------------------------------------------
   logic [7:0] loss_cnt_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         loss_cnt_q <= 8'd0;
      end else if ((state_q == RUN) && (state_d == WAIT_LOCK) && (loss_cnt_q != 8'hFF)) begin
         loss_cnt_q <= loss_cnt_q + 8'd1;
      end
   end

   assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed stimulus with LOCK_FILTER=4, HOLD_CYCLES=8. Stimulus pushes the
// expected output events (cycle number + state) into a queue; a monitor on
// the falling edge detects every change of {sys_reset, ready, state_dbg},
// pops the next expected event and compares. Events that never show up are
// reported once their cycle has passed. Define PLL_LOCK_LOSS_COUNT_EN to
// also exercise the lock-loss counter.
//
// Timing convention: an input driven at the falling edge while cyc==c is
// first sampled by posedge c+1; the FSM sees it at posedge c+3.
// ----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       pll_lock;
   logic       rst_req;
   logic       sys_reset;
   logic       ready;
   logic [1:0] state_dbg;
`ifdef PLL_LOCK_LOSS_COUNT_EN
   logic [7:0] lock_loss_cnt;
`endif

   pll_reset_sequencer #(
      .LOCK_FILTER (4),
      .HOLD_CYCLES (8),
      .CNT_W       (16)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .pll_lock  (pll_lock),
      .rst_req   (rst_req),
      .sys_reset (sys_reset),
      .ready     (ready),
`ifdef PLL_LOCK_LOSS_COUNT_EN
      .lock_loss_cnt (lock_loss_cnt),
`endif
      .state_dbg (state_dbg)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [1:0] st;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;

   task automatic push(input int c, input logic [1:0] st);
      ev_t e;
      e.cyc = c;
      e.st  = st;
      exp_q.push_back(e);
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) @(negedge clock);
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", name, got, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor: {sys_reset, ready, state_dbg}; reset values are the baseline.
   // ------------------------------------------------------------------------
   logic [3:0] prev = 4'b1000;
   always @(negedge clock) begin
      logic [3:0] cur, expv;
      ev_t e;
      cur = {sys_reset, ready, state_dbg};
      if (cur !== prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d got sr=%0b rdy=%0b st=%0d exp no change",
                     cyc, cur[3], cur[2], cur[1:0]);
         end else begin
            e = exp_q.pop_front();
            expv = {(e.st != 2'd3), (e.st == 2'd3), e.st};
            if (cyc != e.cyc || cur !== expv) begin
               failures++;
               $display("FAIL event got cyc=%0d sr=%0b rdy=%0b st=%0d exp cyc=%0d sr=%0b rdy=%0b st=%0d",
                        cyc, cur[3], cur[2], cur[1:0], e.cyc, expv[3], expv[2], expv[1:0]);
            end
         end
         prev = cur;
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
         e = exp_q.pop_front();
         checks++;
         failures++;
         $display("FAIL missed_event exp cyc=%0d st=%0d, got nothing by cyc=%0d", e.cyc, e.st, cyc);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int c;
      reset_n  = 1'b1;
      pll_lock = 1'b0;
      rst_req  = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset_sys_reset", {7'd0, sys_reset}, 8'd1);
      chk("reset_ready", {7'd0, ready}, 8'd0);
      chk("reset_state", {6'd0, state_dbg}, 8'd0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      chk("reset_loss_cnt", lock_loss_cnt, 8'd0);
`endif
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      // Clean lock rise: STABLE, HOLD, RUN; 14 edges from first sampling edge.
      c = cyc;
      pll_lock = 1'b1;
      push(c + 3, 2'd1);
      push(c + 7, 2'd2);
      push(c + 15, 2'd3);
      wait_to(c + 20);

      // Lock loss from RUN, then a one-cycle glitch at filter count 3.
      c = cyc;
      pll_lock = 1'b0;
      push(c + 3, 2'd0);
      wait_to(c + 8);
      c = cyc;
      pll_lock = 1'b1;
      push(c + 3, 2'd1);
      wait_to(c + 3);
      pll_lock = 1'b0;
      push(c + 6, 2'd0);
      wait_to(c + 4);
      pll_lock = 1'b1;
      push(c + 7, 2'd1);
      push(c + 11, 2'd2);
      push(c + 19, 2'd3);
      wait_to(c + 24);

      // 5-cycle rst_req in RUN: HOLD on 3rd edge, RUN 8 edges after last req_s.
      c = cyc;
      rst_req = 1'b1;
      push(c + 3, 2'd2);
      push(c + 15, 2'd3);
      wait_to(c + 5);
      rst_req = 1'b0;
      wait_to(c + 20);

      // Simultaneous lock loss and request in RUN: lock loss wins.
      c = cyc;
      pll_lock = 1'b0;
      rst_req  = 1'b1;
      push(c + 3, 2'd0);
      wait_to(c + 1);
      rst_req = 1'b0;
      wait_to(c + 6);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      chk("loss_cnt_after_two", lock_loss_cnt, 8'd2);
`endif

      // Async reset mid-HOLD at hold count 5, then full restart.
      c = cyc;
      pll_lock = 1'b1;
      push(c + 3, 2'd1);
      push(c + 7, 2'd2);
      wait_to(c + 12);
      #2 reset_n = 1'b0;
      #1;
      chk("async_sys_reset", {7'd0, sys_reset}, 8'd1);
      chk("async_ready", {7'd0, ready}, 8'd0);
      chk("async_state", {6'd0, state_dbg}, 8'd0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      chk("async_loss_cnt", lock_loss_cnt, 8'd0);
`endif
      push(c + 13, 2'd0);
      wait_to(c + 15);
      c = cyc;
      reset_n = 1'b1;
      push(c + 3, 2'd1);
      push(c + 7, 2'd2);
      push(c + 15, 2'd3);
      wait_to(c + 20);

`ifdef PLL_LOCK_LOSS_COUNT_EN
      // 300 RUN -> lock-loss cycles: counter saturates at 255.
      for (int i = 0; i < 300; i++) begin
         c = cyc;
         pll_lock = 1'b0;
         push(c + 3, 2'd0);
         wait_to(c + 5);
         pll_lock = 1'b1;
         push(c + 8, 2'd1);
         push(c + 12, 2'd2);
         push(c + 20, 2'd3);
         wait_to(c + 22);
      end
      chk("loss_cnt_saturated", lock_loss_cnt, 8'd255);
`endif

      wait_to(cyc + 5);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_events got=%0d exp=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
